// File: rtl/m_alu_execute_pkg.sv
// Shared ALU control definitions: the decoder and the execute stage both import these types.
package m_alu_execute_pkg;

    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_AND = 4'd1,
        OP_XOR = 4'd2,
        OP_SHL = 4'd3,
        OP_SHR = 4'd4,
        OP_ASL = 4'd5,
        OP_ASR = 4'd6,
        OP_ROL = 4'd7,
        OP_ROR = 4'd8
    } e_core_op;

    typedef enum logic [1:0] {
        UN_ID  = 2'd0,
        UN_NOT = 2'd1,
        UN_NEG = 2'd2
    } e_unary_op;

    typedef enum logic [1:0] {
        SHIFT_SHL = 2'd0,
        SHIFT_SHR = 2'd1,
        SHIFT_ASR = 2'd2,
        SHIFT_ROR = 2'd3
    } e_shift_kind;

    typedef struct packed {
        e_shift_kind          shift_kind;
        logic [SHAMT_W-1:0]   shift_amt;
    } s_shift;

    typedef struct packed {
        e_core_op   core_op;
        e_unary_op  unary_a;
        e_unary_op  unary_b;
        s_shift     shift;
        e_unary_op  unary_r;
    } s_control;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } s_alu_flags;

endpackage

// File: rtl/m_alu_execute_shifter.sv
// Combinational barrel shifter: logical left/right, arithmetic right and rotate right.
module m_alu_shifter
    import m_alu_execute_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]          value,
    input  logic [$clog2(XLEN)-1:0]  amount,
    input  e_shift_kind              kind,
    output logic [XLEN-1:0]          result
);

    always_comb begin
        result = value;
        case (kind)
            SHIFT_SHL: result = value << amount;
            SHIFT_SHR: result = value >> amount;
            SHIFT_ASR: result = $signed(value) >>> amount;
            // A left shift by XLEN yields zero, so amount 0 falls out as identity.
            default:   result = (value >> amount) | (value << (XLEN - int'(amount)));
        endcase
    end

endmodule

// File: rtl/m_alu_execute.sv
// Two-stage ALU execute: stage 1 prepares operands (unary ops, B shift), stage 2 runs the core op and flags.
module m_alu_execute
    import m_alu_execute_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  s_control          in_control,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic [3:0]        out_flags
);

    localparam int SH_W = $clog2(XLEN);

    function automatic logic [XLEN-1:0] f_unary(input e_unary_op op, input logic [XLEN-1:0] x);
        case (op)
            UN_NOT:  return ~x;
            UN_NEG:  return ~x + XLEN'(1);
            default: return x;
        endcase
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic [XLEN-1:0]   s1_a_q, s1_a_d;
    logic [XLEN-1:0]   s1_b_q, s1_b_d;
    e_core_op          s1_op_q, s1_op_d;
    e_unary_op         s1_unr_q, s1_unr_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

    logic              s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]   s2_result_q, s2_result_d;
    logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
    s_alu_flags        s2_flags_q, s2_flags_d;

    logic              s1_advance;
    logic              in_fire;
    logic              s2_load;
    logic [XLEN-1:0]   b_unary;
    logic [XLEN-1:0]   b_shifted;
    e_shift_kind       core_kind;
    logic [SH_W-1:0]   core_amt;
    logic [XLEN-1:0]   core_shifted;
    logic [XLEN:0]     sum;
    logic [XLEN-1:0]   core_res;
    logic [XLEN-1:0]   final_res;
    logic              core_c;
    logic              core_v;

    assign s1_advance = !s2_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s1_advance;
    assign in_fire    = in_valid && in_ready;
    assign s2_load    = s1_advance && s1_valid_q;

    assign b_unary = f_unary(in_control.unary_b, in_b);

    m_alu_shifter #(.XLEN(XLEN)) u_operand_shift (
        .value  (b_unary),
        .amount (SH_W'(in_control.shift.shift_amt)),
        .kind   (in_control.shift.shift_kind),
        .result (b_shifted)
    );

    // Core shifts reuse one shifter; ROL becomes ROR by the negated amount.
    always_comb begin
        core_kind = SHIFT_SHL;
        core_amt  = s1_b_q[SH_W-1:0];
        case (s1_op_q)
            OP_SHR:  core_kind = SHIFT_SHR;
            OP_ASR:  core_kind = SHIFT_ASR;
            OP_ROR:  core_kind = SHIFT_ROR;
            OP_ROL: begin
                core_kind = SHIFT_ROR;
                core_amt  = SH_W'(0) - s1_b_q[SH_W-1:0];
            end
            default: ;
        endcase
    end

    m_alu_shifter #(.XLEN(XLEN)) u_core_shift (
        .value  (s1_a_q),
        .amount (core_amt),
        .kind   (core_kind),
        .result (core_shifted)
    );

    always_comb begin
        sum      = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        core_res = '0;
        core_c   = 1'b0;
        core_v   = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                core_res = sum[XLEN-1:0];
                core_c   = sum[XLEN];
                core_v   = (s1_a_q[XLEN-1] == s1_b_q[XLEN-1]) && (sum[XLEN-1] != s1_a_q[XLEN-1]);
            end
            OP_AND: core_res = s1_a_q & s1_b_q;
            OP_XOR: core_res = s1_a_q ^ s1_b_q;
            OP_SHL, OP_SHR, OP_ASL, OP_ASR, OP_ROL, OP_ROR: core_res = core_shifted;
            default: ;
        endcase
        final_res = f_unary(s1_unr_q, core_res);
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        s1_unr_d    = s1_unr_q;
        s1_tag_d    = s1_tag_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_tag_d    = s2_tag_q;
        s2_flags_d  = s2_flags_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_a_d   = f_unary(in_control.unary_a, in_a);
            s1_b_d   = b_shifted;
            s1_op_d  = in_control.core_op;
            s1_unr_d = in_control.unary_r;
            s1_tag_d = in_tag;
        end
        if (s1_advance) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            s2_result_d  = final_res;
            s2_tag_d     = s1_tag_q;
            s2_flags_d.z = (final_res == '0);
            s2_flags_d.n = final_res[XLEN-1];
            s2_flags_d.c = core_c;
            s2_flags_d.v = core_v;
        end
        // Flush kills occupancy only; stale data is harmless once valid is low.
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= OP_ADD;
            s1_unr_q    <= UN_ID;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_tag_q    <= '0;
            s2_flags_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_unr_q    <= s1_unr_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_tag_q    <= s2_tag_d;
            s2_flags_q  <= s2_flags_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_tag    = s2_tag_q;
    assign out_flags  = s2_flags_q;

endmodule

// File: tb/tb_m_alu_execute.sv
// Scoreboard bench for m_alu_execute: directed ops, backpressure, flush and mid-stream reset.
module tb_m_alu_execute;
    import m_alu_execute_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    s_control    in_control = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic [3:0]  out_flags;

    m_alu_execute #(.XLEN(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_control (in_control),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] r;
        logic [4:0]  tag;
        logic [3:0]  f;
        int          issue;
        int          lat;
        bit          consec;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          last_out_cyc = -10;
    logic [4:0]  next_tag = 5'd1;

    function automatic s_control mk(input logic [3:0] op, input e_unary_op ua, input e_unary_op ub,
                                    input e_shift_kind sk, input logic [4:0] sa, input e_unary_op ur);
        s_control c;
        c.core_op          = e_core_op'(op);
        c.unary_a          = ua;
        c.unary_b          = ub;
        c.shift.shift_kind = sk;
        c.shift.shift_amt  = sa;
        c.unary_r          = ur;
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic send(input s_control c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [3:0] f, input bit push,
                        input int lat, input bit consec);
        exp_t e;
        bit   accepted = 0;
        in_control = c;
        in_a       = a;
        in_b       = b;
        in_tag     = next_tag;
        in_valid   = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (accepted) begin
            e.r = r; e.tag = next_tag; e.f = f; e.issue = cyc; e.lat = lat; e.consec = consec;
            if (push) sb.push_back(e);
            $display("in  tag=%0d a=0x%08h b=0x%08h expect=0x%08h flags=%b%s",
                     next_tag, a, b, r, f, push ? "" : " (dropped)");
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: tag %0d never saw in_ready, required 1", next_tag);
        end
        in_valid = 1'b0;
        next_tag = next_tag + 5'd1;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, required 0", sb.size());
        end
    endtask

    initial begin
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (!rst && out_valid && out_ready) begin
                        $display("out tag=%0d result=0x%08h flags=%b", out_tag, out_result, out_flags);
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_output: tag %0d result 0x%08h, required none",
                                     out_tag, out_result);
                        end else begin
                            e = sb.pop_front();
                            check("result", out_result, e.r);
                            check("tag", 32'(out_tag), 32'(e.tag));
                            check("flags", 32'(out_flags), 32'(e.f));
                            if (e.lat != 0) check("latency", 32'(cyc - e.issue), 32'(e.lat));
                            if (e.consec) check("consecutive", 32'(cyc), 32'(last_out_cyc + 1));
                        end
                        last_out_cyc = cyc;
                    end
                end
            end
            begin : stimulus
                repeat (2) @(posedge clk);
                #1;
                check("reset_out_valid", 32'(out_valid), 32'd0);
                check("reset_out_result", out_result, 32'd0);
                check("reset_out_tag", 32'(out_tag), 32'd0);
                check("reset_out_flags", 32'(out_flags), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                #1;
                check("reset_in_ready", 32'(in_ready), 32'd1);
                @(posedge clk);
                #1;

                // Directed vectors, out_ready held high; flags are {Z,N,C,V}.
                send(mk(4'd0, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'd5, 32'd7, 32'd12, 4'b0000, 1, 2, 0);
                send(mk(4'd0, UN_ID, UN_NEG, SHIFT_SHL, 5'd0, UN_ID), 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b0100, 1, 0, 0);
                send(mk(4'd0, UN_ID, UN_NEG, SHIFT_SHL, 5'd0, UN_ID), 32'd5, 32'd5, 32'd0, 4'b1010, 1, 0, 0);
                send(mk(4'd0, UN_ID, UN_NEG, SHIFT_SHL, 5'd0, UN_ID), 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0101, 1, 0, 0);
                send(mk(4'd1, UN_NOT, UN_NOT, SHIFT_SHL, 5'd0, UN_NOT), 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 4'b0100, 1, 0, 0);
                send(mk(4'd1, UN_ID, UN_ID, SHIFT_SHL, 5'd4, UN_ID), 32'hFFFF_FFFF, 32'd1, 32'h10, 4'b0000, 1, 0, 0);
                send(mk(4'd8, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'd1, 32'd1, 32'h8000_0000, 4'b0100, 1, 0, 0);
                send(mk(4'd7, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'h8000_0000, 32'd1, 32'd1, 4'b0000, 1, 0, 0);
                send(mk(4'd6, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'h8000_0000, 32'd4, 32'hF800_0000, 4'b0100, 1, 0, 0);
                send(mk(4'd3, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'd1, 32'd33, 32'd2, 4'b0000, 1, 0, 0);
                send(mk(4'd2, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'hFF, 32'h0F, 32'hF0, 4'b0000, 1, 0, 0);
                send(mk(4'd15, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'h1234, 32'h5678, 32'd0, 4'b1000, 1, 0, 0);
                send(mk(4'd0, UN_ID, UN_ID, SHIFT_ROR, 5'd1, UN_ID), 32'd0, 32'd1, 32'h8000_0000, 4'b0100, 1, 0, 0);
                send(mk(4'd0, UN_ID, UN_ID, SHIFT_ASR, 5'd31, UN_ID), 32'd1, 32'h8000_0000, 32'd0, 4'b1010, 1, 0, 0);
                send(mk(4'd0, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_NEG), 32'd1, 32'd0, 32'hFFFF_FFFF, 4'b0100, 1, 0, 0);
                send(mk(4'd0, UN_NEG, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'd2, 32'd2, 32'd0, 4'b1010, 1, 0, 0);
                send(mk(4'd5, UN_ID, UN_ID, SHIFT_SHR, 5'd1, UN_ID), 32'h3, 32'h8, 32'h30, 4'b0000, 1, 0, 0);
                drain();

                // Backpressure: two ops fill the pipe, the rest wait for release.
                out_ready = 1'b0;
                fork
                    begin
                        repeat (5) @(posedge clk);
                        #1;
                        out_ready = 1'b1;
                    end
                    begin
                        send(mk(4'd0, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'd1, 32'd0, 32'd1, 4'b0000, 1, 0, 0);
                        send(mk(4'd0, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'd2, 32'd0, 32'd2, 4'b0000, 1, 0, 1);
                        check("full_in_ready", 32'(in_ready), 32'd0);
                        send(mk(4'd0, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'd3, 32'd0, 32'd3, 4'b0000, 1, 0, 1);
                        send(mk(4'd0, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'd4, 32'd0, 32'd4, 4'b0000, 1, 0, 1);
                    end
                join
                drain();

                // Flush with two ops in flight and a third offered.
                out_ready = 1'b0;
                send(mk(4'd0, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'h11, 32'd0, 32'h11, 4'b0000, 0, 0, 0);
                send(mk(4'd0, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'h22, 32'd0, 32'h22, 4'b0000, 0, 0, 0);
                in_a     = 32'h33;
                in_tag   = next_tag;
                in_valid = 1'b1;
                flush    = 1'b1;
                @(posedge clk);
                #1;
                flush    = 1'b0;
                in_valid = 1'b0;
                next_tag = next_tag + 5'd1;
                check("flush_out_valid", 32'(out_valid), 32'd0);
                check("flush_in_ready", 32'(in_ready), 32'd1);
                out_ready = 1'b1;
                repeat (6) @(posedge clk);
                #1;
                send(mk(4'd0, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'd9, 32'd1, 32'd10, 4'b0000, 1, 0, 0);
                drain();

                // Asynchronous reset in the middle of a cycle with a full pipe.
                out_ready = 1'b0;
                send(mk(4'd0, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'h55, 32'd0, 32'h55, 4'b0000, 0, 0, 0);
                send(mk(4'd0, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'h66, 32'd0, 32'h66, 4'b0000, 0, 0, 0);
                #2;
                rst = 1'b1;
                #1;
                check("async_rst_out_valid", 32'(out_valid), 32'd0);
                check("async_rst_out_result", out_result, 32'd0);
                check("async_rst_out_tag", 32'(out_tag), 32'd0);
                check("async_rst_out_flags", 32'(out_flags), 32'd0);
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                #1;
                check("post_rst_in_ready", 32'(in_ready), 32'd1);
                out_ready = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                check("post_rst_out_valid", 32'(out_valid), 32'd0);
                send(mk(4'd2, UN_ID, UN_ID, SHIFT_SHL, 5'd0, UN_ID), 32'hA5, 32'h0F, 32'hAA, 4'b0000, 1, 2, 0);
                drain();

                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        join_any
    end

endmodule

// File: doc/m_alu_execute.md
Name: m_alu_execute

Overview:
- Execute stage directly downstream of m_decoder_alu.
- Consumes the decoded s_control word (core op, unary ops on A/B/result, operand-B shift) together with two register operands. Produces the ALU result, destination tag and condition flags.
- Two-stage pipeline with valid/ready handshakes on both sides, a synchronous flush, and full throughput of one op per cycle.

Parameters:
- XLEN, 32, operand/result width (power of two; shift amounts use log2(XLEN) bits).
- TAG_W, 5, width of destination-register tag carried alongside the op.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all in-flight ops (synchronous).
- in_valid  in  1  upstream op valid.
- in_ready  out  1  stage can accept op this cycle.
- in_control  in  $bits(s_control)  decoded control {core_op, unary_a, unary_b, {shift_kind, shift_amt[4:0]}, unary_r}.
- in_a  in  XLEN  operand A.
- in_b  in  XLEN  operand B.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_result  out  XLEN  final result.
- out_tag  out  TAG_W  tag of out_result.
- out_flags  out  4  {Z, N, C, V}.

Behaviour:
- Reset (async assert, sync release): both stage valids 0; out_valid=0, out_result=0, out_tag=0, out_flags=0. in_ready=1 once reset is deasserted.
- Handshake:
  - Transfer occurs when valid&&ready on the same edge.
  - in_ready = !s1_valid || s1_advance, where s1_advance = !s2_valid || out_ready. This is combinational; there is no in_valid->in_ready path.
  - out_valid/out_result/out_tag/out_flags are held stable while out_valid && !out_ready.
- Stage 1 (operand prep, registered):
  - a1 = U(unary_a, in_a).
  - b1 = SH(shift_kind, shift_amt, U(unary_b, in_b)).
  - core_op, unary_r and tag are latched with a1/b1.
  - U: ID = x, NOT = ~x, NEG = ~x+1 (mod 2^XLEN).
  - SH kinds:
    - SHIFT_SHL: logical left.
    - SHIFT_SHR: logical right.
    - SHIFT_ASR: arithmetic right.
    - SHIFT_ROR: rotate right.
  - Amount 0 = identity.
- Stage 2 (core op, registered to outputs):
  - ADD: 33-bit sum {0,a1}+{0,b1}; C = sum[XLEN]; V = (a1[msb]==b1[msb]) && (sum[msb]!=a1[msb]).
  - AND, XOR: bitwise.
  - SHL, SHR, ASL, ASR, ROL, ROR: shift a1 by b1[log2(XLEN)-1:0]. Upper bits of b1 are ignored. ASL is identical to SHL.
  - C=V=0 for every op other than ADD.
  - r = U(unary_r, core result). Z = (r==0); N = r[msb]. Z and N reflect the final r, not the core result.
- Latency: 2 cycles from accepted input to out_valid when out_ready is held high. Throughput is 1/cycle.
- Backpressure: with out_ready low, the pipeline fills to 2 entries and then deasserts in_ready. Ordering is strictly FIFO with no drop or duplication.
- Flush:
  - At the edge where flush=1, s1_valid and s2_valid clear; out_valid is 0 the next cycle.
  - An input handshake in the flush cycle is discarded.
  - A result handshake in the flush cycle (out_valid && out_ready) still counts as delivered.
  - Data registers need not clear.
- Simultaneous flush and rst: rst dominates.
- Reset mid-operation: all in-flight ops are lost; no output after reset until a new input is accepted.
- Undefined core_op encodings produce r = 0 with flags computed normally (Z=1).

Decomposition:
- The shared package holds e_core_op, e_unary_op, e_shift_kind, s_shift, s_control and a flags struct s_alu_flags {z, n, c, v}. These are the same definitions m_decoder_alu uses; no local redefinition.
- One natural sub-module, m_alu_shifter (combinational: value, amount, kind -> result). It is instantiated once for the stage-1 operand shift and once for the stage-2 core shift/rotate. ROL is implemented as ROR by (XLEN-amt) mod XLEN.

Test Plan:
- ADD/ID/ID/SHL0/ID, a=5, b=7, out_ready=1 -> out_result=12 exactly 2 cycles after accept, flags Z0 N0 C0 V0.
- ADD with unary_b=NEG:
  - a=3, b=5 -> 0xFFFFFFFE, N=1, C=0.
  - a=5, b=5 -> 0, Z=1, C=1.
  - a=0x7FFFFFFF, b=0xFFFFFFFF -> 0x80000000, V=1.
- AND with NOT/NOT/NOT (OR), a=0xF0F00000, b=0x00000F0F -> 0xF0F00F0F. Operand shift SHIFT_SHL by 4 on AND/ID, a=0xFFFFFFFF, b=0x1 -> 0x10.
- Shifts:
  - ROR a=1, b=1 -> 0x80000000.
  - ROL a=0x80000000, b=1 -> 1.
  - ASR a=0x80000000, b=4 -> 0xF8000000.
  - SHL a=1, b=33 -> 2 (amount b[4:0]=1).
- Backpressure: 4 back-to-back ADDs (results 1,2,3,4) with out_ready low for 5 cycles -> in_ready=0 after 2 accepted; on release, results emerge 1,2,3,4 in order on consecutive cycles.
- Flush with 2 ops in flight plus in_valid -> out_valid=0 next cycle, none of the 3 ever appear. Async rst pulse mid-stream -> outputs 0 immediately, in_ready=1 after release.
